// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 arbiter feeding a registered select/data stage; owner keeps grant up to BURST words under contention.
// Latency: a word accepted on edge N is on y_data/y_valid after edge N (one register stage).
// Backpressure: when y holds an unconsumed word and y_ready=0 both readys drop and y_data/sel hold.
module mux2_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready
);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            ptr;
    logic            load;
    logic            gnt_vld;
    logic            gnt_idx;
    logic            burst_left;
    logic            same_owner;

    assign load       = !y_valid || y_ready;
    assign burst_left = cnt < CW'(BURST);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    gnt_vld = 1'b1;
                    gnt_idx = ptr;
                end else if (a_valid || b_valid) begin
                    gnt_vld = 1'b1;
                    gnt_idx = b_valid;
                end
            end
            OWN_A: begin
                if (a_valid && (burst_left || !b_valid)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b0;
                end else if (b_valid) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b1;
                end
            end
            OWN_B: begin
                if (b_valid && (burst_left || !a_valid)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b1;
                end else if (a_valid) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Readys are forced low while reset is asserted so nothing is accepted into a clearing register.
    assign a_ready    = rst_n && load && gnt_vld && !gnt_idx;
    assign b_ready    = rst_n && load && gnt_vld && gnt_idx;
    assign same_owner = (state == OWN_A && !gnt_idx) || (state == OWN_B && gnt_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= 1'b0;
            sel     <= 1'b0;
            y_valid <= 1'b0;
            y_data  <= '0;
        end else if (load) begin
            if (gnt_vld) begin
                y_data  <= gnt_idx ? b_data : a_data;
                y_valid <= 1'b1;
                sel     <= gnt_idx;
                state   <= gnt_idx ? OWN_B : OWN_A;
                ptr     <= !gnt_idx;
                if (same_owner)
                    cnt <= burst_left ? cnt + 1'b1 : cnt;
                else
                    cnt <= CW'(1);
            end else begin
                // Nothing to refill with: empty the register and forget ownership, keep ptr.
                y_valid <= 1'b0;
                state   <= IDLE;
                cnt     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: directed scenarios followed by randomized traffic.
module tb_mux2_rr_arbiter;
    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_ready;
    logic             sel;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready = 1'b0;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .sel     (sel),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: who last won, how many in a row, who is preferred on a tie from idle.
    int   run_src  = -1;
    int   run_len  = 0;
    int   pref     = 0;
    bit   y_full   = 1'b0;
    int   m_grant;
    bit   m_load;
    exp_t m_exp;
    exp_t mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int pick(input bit av, input bit bv);
        if (!av && !bv) return -1;
        if (av && !bv)  return 0;
        if (bv && !av)  return 1;
        if (run_src < 0) return pref;
        if (run_len < BURST) return run_src;
        return 1 - run_src;
    endfunction

    always @(negedge rst_n) begin
        sb_q.delete();
        y_full  = 1'b0;
        run_src = -1;
        run_len = 0;
        pref    = 0;
    end

    // Model/predictor: checks readys and occupancy, pushes the word expected after the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
            chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
            chk("rst_y_valid", {31'b0, y_valid}, 32'd0);
            chk("rst_y_data", {24'b0, y_data}, 32'd0);
            chk("rst_sel", {31'b0, sel}, 32'd0);
        end else begin
            m_load = !y_full || y_ready;
            chk("y_valid", {31'b0, y_valid}, {31'b0, y_full});
            m_grant = m_load ? pick(a_valid, b_valid) : -1;
            chk("a_ready", {31'b0, a_ready}, {31'b0, m_grant == 0});
            chk("b_ready", {31'b0, b_ready}, {31'b0, m_grant == 1});
            if (m_grant >= 0) begin
                m_exp.sel = (m_grant == 1);
                m_exp.dat = (m_grant == 1) ? b_data : a_data;
                sb_q.push_back(m_exp);
                if (m_grant == run_src) run_len++;
                else begin
                    run_src = m_grant;
                    run_len = 1;
                end
                pref   = 1 - m_grant;
                y_full = 1'b1;
            end else if (m_load) begin
                y_full  = 1'b0;
                run_src = -1;
                run_len = 0;
            end
        end
    end

    // Monitor: compares each word as downstream consumes it.
    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_word", {24'b0, y_data}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("y_data", {24'b0, y_data}, {24'b0, mon_exp.dat});
                chk("sel", {31'b0, sel}, {31'b0, mon_exp.sel});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input logic [WIDTH-1:0] ad,
                         input bit bv, input logic [WIDTH-1:0] bd, input bit yr);
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        y_ready = yr;
    endtask

    initial begin
        // Reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            step(1);
        end
        drive(0, 8'h00, 0, 8'h00, 1);
        rst_n = 1'b1;
        step(1);

        // Single A word.
        drive(1, 8'h07, 0, 8'h00, 1);
        step(1);
        drive(0, 8'h00, 0, 8'h00, 1);
        step(2);

        // Sustained contention: bursts of BURST per source.
        drive(1, 8'h85, 1, 8'h25, 1);
        step(14);

        // Stalled output, then resume.
        drive(1, 8'h11, 1, 8'h22, 0);
        step(5);
        drive(1, 8'h13, 1, 8'h24, 1);
        step(3);

        // A owns for two words then drops; B takes over immediately.
        drive(0, 8'h00, 0, 8'h00, 1);
        step(1);
        drive(1, 8'h41, 0, 8'h00, 1);
        step(2);
        drive(0, 8'h00, 1, 8'h34, 1);
        step(1);

        // Asynchronous reset pulse in the middle of a B burst; A wins first afterwards.
        drive(0, 8'h00, 1, 8'h5B, 0);
        step(2);
        drive(1, 8'hA1, 1, 8'hB1, 1);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step(4);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step(1);
        end

        // Drain and confirm every expected word was seen.
        drive(0, 8'h00, 0, 8'h00, 1);
        step(4);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
